// File: rtl/alu_serial_driver.sv
// alu_serial_driver: sequences one operation through an external bit-serial ALU.
// Operands go out LSB first on X/Y together with constant control lines. The
// result bits come back ALU_LAT cycles later and are collected into res_sum.
// Each returning bit is identified by a valid/last tag pipeline, so no bit
// position is guessed from a cycle count.
// Optional feature: define ALU_SERIAL_DRIVER_FLAGS_EN to capture Carry_out and
// Overflow into res_cout/res_ovf. Without it those outputs are tied to 0.
module alu_serial_driver #(
  parameter int WIDTH   = 8,
  parameter int ALU_LAT = 6
) (
  input  logic             gclk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             X,
  output logic             Y,
  output logic             Carry_in,
  output logic             End,
  output logic             Cmpl_X,
  output logic             Cmpl_Y,
  output logic             Op_XOR,
  output logic             Op_AND,
  output logic             Op_ARITH,
  input  logic             Sum,
  input  logic             Carry_out,
  input  logic             Overflow,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_ovf,
  output logic             res_err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, DONE} state_t;

  state_t state;
  state_t state_nxt;

  // Control word layout: [5] carry seed, [4] Cmpl_X, [3] Cmpl_Y,
  // [2] Op_XOR, [1] Op_AND, [0] Op_ARITH. Reserved opcodes decode to all zero.
  function automatic logic [5:0] decode_ctrl(input logic [2:0] op);
    case (op)
      3'b000:  decode_ctrl = 6'b000001;  // ADD
      3'b001:  decode_ctrl = 6'b101001;  // SUB  A + ~B + 1
      3'b010:  decode_ctrl = 6'b110001;  // RSUB B + ~A + 1
      3'b011:  decode_ctrl = 6'b000100;  // XOR
      3'b100:  decode_ctrl = 6'b000010;  // AND
      default: decode_ctrl = 6'b000000;
    endcase
  endfunction

  function automatic logic is_reserved(input logic [2:0] op);
    is_reserved = (op > 3'b100);
  endfunction

  logic signed [WIDTH-1:0] a_q;
  logic signed [WIDTH-1:0] b_q;
  logic [5:0]              ctrl_q;
  logic                    err_q;
  logic [CW-1:0]           cnt;
  logic [ALU_LAT-1:0]      vld_p;
  logic [ALU_LAT-1:0]      last_p;

  logic accept;
  logic shifting;
  logic bit_last;
  logic ret_vld;
  logic ret_done;

  assign accept   = (state == IDLE) && in_valid;
  assign shifting = (state == SHIFT);
  assign bit_last = (cnt == LAST_BIT);
  assign ret_vld  = vld_p[ALU_LAT-1];
  assign ret_done = vld_p[ALU_LAT-1] && last_p[ALU_LAT-1];

  // State register.
  always_ff @(posedge gclk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state plus all handshake and ALU-facing outputs; everything is 0 outside SHIFT.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    X         = 1'b0;
    Y         = 1'b0;
    Carry_in  = 1'b0;
    End       = 1'b0;
    Cmpl_X    = 1'b0;
    Cmpl_Y    = 1'b0;
    Op_XOR    = 1'b0;
    Op_AND    = 1'b0;
    Op_ARITH  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        // A reserved opcode still runs WIDTH cycles but drives nothing to the ALU.
        X        = a_q[cnt] & ~err_q;
        Y        = b_q[cnt] & ~err_q;
        End      = bit_last & ~err_q;
        Carry_in = ctrl_q[5] && (cnt == '0);
        Cmpl_X   = ctrl_q[4];
        Cmpl_Y   = ctrl_q[3];
        Op_XOR   = ctrl_q[2];
        Op_AND   = ctrl_q[1];
        Op_ARITH = ctrl_q[0];
        if (bit_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (ret_done) state_nxt = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand and opcode latch at accept; these are gated by state, so they need no reset.
  always_ff @(posedge gclk) begin
    if (accept) begin
      a_q    <= in_a;
      b_q    <= in_b;
      ctrl_q <= decode_ctrl(in_op);
      err_q  <= is_reserved(in_op);
    end
  end

  // Bit position counter for the SHIFT phase.
  always_ff @(posedge gclk) begin
    if (!rst_n)        cnt <= '0;
    else if (accept)   cnt <= '0;
    else if (shifting) cnt <= cnt + 1'b1;
  end

  // ---- stage boundary: bit issued to ALU -> bit returned ALU_LAT cycles later ----
  // Tag pipeline that mirrors the ALU delay. Reset empties it, so bits of an abandoned operation are ignored.
  always_ff @(posedge gclk) begin
    if (!rst_n) begin
      vld_p  <= '0;
      last_p <= '0;
    end else begin
      for (int k = ALU_LAT - 1; k > 0; k--) begin
        vld_p[k]  <= vld_p[k-1];
        last_p[k] <= last_p[k-1];
      end
      vld_p[0]  <= shifting;
      last_p[0] <= shifting && bit_last;
    end
  end

  // Result assembly: shift returned bits in from the MSB so that bit 0 ends up at the LSB.
  always_ff @(posedge gclk) begin
    if (!rst_n) begin
      res_sum <= '0;
      res_err <= 1'b0;
    end else if (accept) begin
      res_sum <= '0;
      res_err <= 1'b0;
    end else begin
      if (ret_vld)  res_sum <= {Sum & ~err_q, res_sum[WIDTH-1:1]};
      if (ret_done) res_err <= err_q;
    end
  end

`ifdef ALU_SERIAL_DRIVER_FLAGS_EN
  // Carry/overflow capture, taken only with the last-tagged returning bit.
  always_ff @(posedge gclk) begin
    if (!rst_n) begin
      res_cout <= 1'b0;
      res_ovf  <= 1'b0;
    end else if (accept) begin
      res_cout <= 1'b0;
      res_ovf  <= 1'b0;
    end else if (ret_done) begin
      res_cout <= Carry_out & ~err_q;
      res_ovf  <= Overflow & ~err_q;
    end
  end
`else
  logic unused_flags;
  assign unused_flags = Carry_out ^ Overflow;
  assign res_cout     = 1'b0;
  assign res_ovf      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_serial_driver.sv
// Testbench for alu_serial_driver: a behavioural bit-serial ALU sits on the
// X/Y side, and a scoreboard of expected results is pushed at accept time and
// popped when res_valid appears.
module tb_alu_serial_driver;

  localparam int W = 8;
  localparam int L = 6;

`ifdef ALU_SERIAL_DRIVER_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic gclk = 1'b0;
  always #5 gclk = ~gclk;

  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [2:0]   in_op;
  logic         X, Y, Carry_in, End, Cmpl_X, Cmpl_Y, Op_XOR, Op_AND, Op_ARITH;
  logic         Sum, Carry_out, Overflow;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_sum;
  logic         res_cout, res_ovf, res_err;

  alu_serial_driver #(.WIDTH(W), .ALU_LAT(L)) dut (
    .gclk(gclk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .X(X), .Y(Y), .Carry_in(Carry_in), .End(End),
    .Cmpl_X(Cmpl_X), .Cmpl_Y(Cmpl_Y), .Op_XOR(Op_XOR), .Op_AND(Op_AND), .Op_ARITH(Op_ARITH),
    .Sum(Sum), .Carry_out(Carry_out), .Overflow(Overflow),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_cout(res_cout), .res_ovf(res_ovf), .res_err(res_err)
  );

  // Behavioural serial ALU: a full adder with a running carry, plus logic ops, delayed by L cycles.
  logic       carry = 1'b0;
  logic [2:0] dly [L] = '{default: 3'b000};
  logic       x_e, y_e, c_e, s_e, co_e;

  always_comb begin
    x_e  = X ^ Cmpl_X;
    y_e  = Y ^ Cmpl_Y;
    c_e  = carry | Carry_in;
    s_e  = 1'b0;
    co_e = 1'b0;
    if (Op_ARITH) begin
      s_e  = x_e ^ y_e ^ c_e;
      co_e = (x_e & y_e) | (x_e & c_e) | (y_e & c_e);
    end else if (Op_XOR) begin
      s_e = X ^ Y;
    end else if (Op_AND) begin
      s_e = X & Y;
    end
  end

  always @(posedge gclk) begin
    for (int k = L - 1; k > 0; k--) dly[k] <= dly[k-1];
    dly[0] <= {Op_ARITH & End & (c_e ^ co_e), Op_ARITH & End & co_e, s_e};
    carry  <= (Op_ARITH && !End) ? co_e : 1'b0;
  end

  assign Sum       = dly[L-1][0];
  assign Carry_out = dly[L-1][1];
  assign Overflow  = dly[L-1][2];

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Drive one operation, check the serial bus bit by bit, then collect and compare the result.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op, input int stall);
    logic [W:0]    full;
    exp_t          e;
    exp_t          got_res;
    logic [4:0]    ctl;
    logic          seed;
    logic [10:0]   bus_exp;
    logic [10:0]   bus_got;
    logic [W-1:0]  held;
    int            edges;
    bit            got;
    full = '0;
    e    = '0;
    ctl  = 5'b00000;
    seed = 1'b0;
    case (op)
      3'd0: begin
        full = {1'b0, a} + {1'b0, b};
        e.sum = full[W-1:0]; e.cout = full[W];
        e.ovf = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        ctl = 5'b00001;
      end
      3'd1: begin
        full = {1'b0, a} + {1'b0, ~b} + 1'b1;
        e.sum = full[W-1:0]; e.cout = full[W];
        e.ovf = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
        ctl = 5'b01001; seed = 1'b1;
      end
      3'd2: begin
        full = {1'b0, b} + {1'b0, ~a} + 1'b1;
        e.sum = full[W-1:0]; e.cout = full[W];
        e.ovf = (b[W-1] != a[W-1]) && (full[W-1] != b[W-1]);
        ctl = 5'b10001; seed = 1'b1;
      end
      3'd3: begin e.sum = a ^ b; ctl = 5'b00100; end
      3'd4: begin e.sum = a & b; ctl = 5'b00010; end
      default: e.err = 1'b1;
    endcase
    e.cout = e.cout & FLAGS;
    e.ovf  = e.ovf & FLAGS;
    sb.push_back(e);

    res_ready = (stall == 0);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_op got %b want 1", in_ready);
    end
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    edges = 0;
    for (int i = 0; i < W; i++) begin
      @(posedge gclk); #1;
      in_valid = 1'b0;
      edges++;
      bus_exp = {1'b0, 1'b0, a[i] & ~e.err, b[i] & ~e.err, seed && (i == 0),
                 !e.err && (i == W - 1), ctl};
      bus_got = {in_ready, res_valid, X, Y, Carry_in, End,
                 Cmpl_X, Cmpl_Y, Op_XOR, Op_AND, Op_ARITH};
      checks++;
      if (bus_got !== bus_exp) begin
        errors++;
        $display("FAIL shift_bus op=%0d bit=%0d got %b want %b", op, i, bus_got, bus_exp);
      end
    end
    @(posedge gclk); #1;
    edges++;
    bus_got = {in_ready, res_valid, X, Y, Carry_in, End,
               Cmpl_X, Cmpl_Y, Op_XOR, Op_AND, Op_ARITH};
    checks++;
    if (bus_got !== 11'b0) begin
      errors++;
      $display("FAIL drain_bus op=%0d got %b want %b", op, bus_got, 11'b0);
    end
    got = 1'b0;
    while (!got && edges < 40) begin
      @(posedge gclk); #1;
      edges++;
      if (res_valid === 1'b1) got = 1'b1;
    end
    e = sb.pop_front();
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL res_valid_timeout op=%0d got %0d cycles want %0d", op, edges, W + L + 1);
    end else begin
      if (edges != W + L + 1) begin
        errors++;
        $display("FAIL latency op=%0d got %0d want %0d", op, edges, W + L + 1);
      end
      got_res = {res_sum, res_cout, res_ovf, res_err};
      checks++;
      if (got_res !== e) begin
        errors++;
        $display("FAIL result op=%0d a=%h b=%h got sum=%h c=%b v=%b e=%b want sum=%h c=%b v=%b e=%b",
                 op, a, b, res_sum, res_cout, res_ovf, res_err, e.sum, e.cout, e.ovf, e.err);
      end
      held = res_sum;
      for (int s = 0; s < stall; s++) begin
        @(posedge gclk); #1;
        checks++;
        if ({res_valid, in_ready, res_sum} !== {1'b1, 1'b0, held}) begin
          errors++;
          $display("FAIL stall_hold cycle=%0d got v=%b r=%b sum=%h want v=1 r=0 sum=%h",
                   s, res_valid, in_ready, res_sum, held);
        end
      end
      res_ready = 1'b1;
      @(posedge gclk); #1;
      checks++;
      if ({in_ready, res_valid} !== 2'b10) begin
        errors++;
        $display("FAIL return_idle got r=%b v=%b want r=1 v=0", in_ready, res_valid);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; res_ready = 1'b1;
    in_a = '0; in_b = '0; in_op = 3'd0;
    repeat (3) @(posedge gclk);
    #1;
    checks++;
    if ({in_ready, res_valid, res_sum, res_cout, res_ovf, res_err,
         X, Y, Carry_in, End, Cmpl_X, Cmpl_Y, Op_XOR, Op_AND, Op_ARITH} !==
        {1'b1, 1'b0, {W{1'b0}}, 3'b000, 9'b0}) begin
      errors++;
      $display("FAIL reset_state got r=%b v=%b sum=%h flags=%b%b%b want r=1 v=0 sum=00 flags=000",
               in_ready, res_valid, res_sum, res_cout, res_ovf, res_err);
    end
    rst_n = 1'b1;
    @(posedge gclk); #1;
  endtask

  task automatic test_add();
    run_op(8'h35, 8'h4A, 3'd0, 0);
    run_op(8'h7F, 8'h01, 3'd0, 0);
    run_op(8'hFF, 8'h01, 3'd0, 0);
  endtask

  task automatic test_sub();
    run_op(8'h10, 8'h01, 3'd1, 0);
    run_op(8'h80, 8'h01, 3'd1, 0);
    run_op(8'h10, 8'h01, 3'd2, 0);
  endtask

  task automatic test_logic();
    run_op(8'hF0, 8'h3C, 3'd3, 0);
    run_op(8'hF0, 8'h3C, 3'd4, 0);
  endtask

  task automatic test_reserved();
    run_op(8'hAA, 8'h55, 3'd7, 0);
    run_op(8'hFF, 8'hFF, 3'd5, 0);
  endtask

  task automatic test_stall();
    run_op(8'h5A, 8'h21, 3'd0, 5);
  endtask

  task automatic test_midreset();
    in_a = 8'hFF; in_b = 8'h00; in_op = 3'd0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge gclk); #1;
      in_valid = 1'b0;
    end
    checks++;
    if ({X, End} !== 2'b10) begin
      errors++;
      $display("FAIL midreset_bit3 got X=%b End=%b want X=1 End=0", X, End);
    end
    rst_n = 1'b0;
    @(posedge gclk); #1;
    checks++;
    if ({in_ready, res_valid, res_sum, res_cout, res_ovf, res_err,
         X, Y, Carry_in, End, Cmpl_X, Cmpl_Y, Op_XOR, Op_AND, Op_ARITH} !==
        {1'b1, 1'b0, {W{1'b0}}, 3'b000, 9'b0}) begin
      errors++;
      $display("FAIL midreset_state got r=%b v=%b sum=%h X=%b A=%b want r=1 v=0 sum=00 X=0 A=0",
               in_ready, res_valid, res_sum, X, Op_ARITH);
    end
    rst_n = 1'b1;
    run_op(8'h01, 8'h01, 3'd0, 0);
  endtask

  task automatic test_back_to_back();
    run_op(8'h12, 8'h34, 3'd0, 0);
    run_op(8'h34, 8'h12, 3'd2, 0);
    run_op(8'hC3, 8'h0F, 3'd3, 0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_reserved();
    test_stall();
    test_midreset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
